// File: rtl/sccb_cmd_sender.sv
// SCCB (3-wire, write-only) command sender: turns {reg, value} table entries into
// 27-bit write frames with START/STOP, a bus-idle gap, and a one-cycle advance pulse.
module sccb_cmd_sender #(
   parameter int unsigned QTR      = 250,
   parameter logic [7:0]  DEV_ID   = 8'h42,
   parameter int unsigned RST_WAIT = 100000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        en,
   input  logic [15:0] command,
   input  logic        finished,
   output logic        advance,
   output logic        sioc,
   output logic        siod_o,
   output logic        siod_oe,
   output logic        busy,
   output logic        done
);

   localparam int unsigned QW = (QTR > 1) ? $clog2(QTR) : 1;
   localparam int unsigned WW = (RST_WAIT > 1) ? $clog2(RST_WAIT) : 1;
   localparam int unsigned FW = 27;

   typedef enum logic [2:0] {IDLE, START, BITS, STOP, GAP, SKIP, RWAIT} state_t;

   state_t          state, state_nxt;
   logic [QW-1:0]   qcnt, qcnt_nxt;
   logic [1:0]      qidx, qidx_nxt;
   logic [4:0]      bitn, bit_nxt;
   logic [WW-1:0]   wcnt, wcnt_nxt;
   logic [FW-1:0]   frame, frame_nxt;
   logic            rst_cmd, rst_cmd_nxt;
   logic            q_last;
   logic [4:0]      idx;
   logic            sioc_nxt, siod_nxt, oe_nxt, adv_nxt, busy_nxt, done_nxt;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state   <= IDLE;
         qcnt    <= '0;
         qidx    <= '0;
         bitn    <= '0;
         wcnt    <= '0;
         frame   <= '0;
         rst_cmd <= 1'b0;
         sioc    <= 1'b1;
         siod_o  <= 1'b1;
         siod_oe <= 1'b1;
         advance <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_nxt;
         qcnt    <= qcnt_nxt;
         qidx    <= qidx_nxt;
         bitn    <= bit_nxt;
         wcnt    <= wcnt_nxt;
         frame   <= frame_nxt;
         rst_cmd <= rst_cmd_nxt;
         sioc    <= sioc_nxt;
         siod_o  <= siod_nxt;
         siod_oe <= oe_nxt;
         advance <= adv_nxt;
         busy    <= busy_nxt;
         done    <= done_nxt;
      end
   end

   // Outputs are decoded from the next state so registered pins line up with the state register.
   always_comb begin
      state_nxt   = state;
      q_last      = (qcnt == QW'(QTR - 1));
      qcnt_nxt    = q_last ? '0 : qcnt + QW'(1);
      qidx_nxt    = qidx;
      bit_nxt     = bitn;
      wcnt_nxt    = '0;
      frame_nxt   = frame;
      rst_cmd_nxt = rst_cmd;

      case (state)
         IDLE: begin
            qcnt_nxt = '0;
            qidx_nxt = '0;
            bit_nxt  = '0;
            if (en && !finished) begin
               frame_nxt   = {DEV_ID, 1'b1, command[15:8], 1'b1, command[7:0], 1'b1};
               rst_cmd_nxt = (command == 16'h1280);
               state_nxt   = (command == 16'hFFFF) ? SKIP : START;
            end
         end
         START: if (q_last) begin
            qidx_nxt = qidx + 2'd1;
            if (qidx == 2'd1) begin
               qidx_nxt  = '0;
               state_nxt = BITS;
            end
         end
         BITS: if (q_last) begin
            qidx_nxt = qidx + 2'd1;
            if (qidx == 2'd3) begin
               if (bitn == 5'(FW - 1)) begin
                  bit_nxt   = '0;
                  state_nxt = STOP;
               end else begin
                  bit_nxt = bitn + 5'd1;
               end
            end
         end
         STOP: if (q_last) begin
            qidx_nxt = qidx + 2'd1;
            if (qidx == 2'd2) begin
               qidx_nxt  = '0;
               state_nxt = GAP;
            end
         end
         GAP: if (q_last) begin
            qidx_nxt = qidx + 2'd1;
            if (qidx == 2'd3) state_nxt = rst_cmd ? RWAIT : IDLE;
         end
         SKIP: begin
            qcnt_nxt  = '0;
            state_nxt = IDLE;
         end
         RWAIT: begin
            qcnt_nxt = '0;
            wcnt_nxt = wcnt + WW'(1);
            if (wcnt == WW'(RST_WAIT - 1)) begin
               wcnt_nxt  = '0;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase

      sioc_nxt = 1'b1;
      siod_nxt = 1'b1;
      oe_nxt   = 1'b1;
      adv_nxt  = 1'b0;
      idx      = 5'(FW - 1) - bit_nxt;

      case (state_nxt)
         START: siod_nxt = (qidx_nxt == 2'd0);
         BITS: begin
            sioc_nxt = qidx_nxt[1];
            siod_nxt = frame_nxt[idx];
            oe_nxt   = !((bit_nxt == 5'd8) || (bit_nxt == 5'd17) || (bit_nxt == 5'd26));
         end
         STOP: begin
            sioc_nxt = (qidx_nxt != 2'd0);
            siod_nxt = (qidx_nxt == 2'd2);
         end
         GAP:     adv_nxt = (qidx_nxt == 2'd3) && (qcnt_nxt == QW'(QTR - 1));
         SKIP:    adv_nxt = 1'b1;
         default: ;
      endcase

      busy_nxt = (state_nxt != IDLE);
      done_nxt = (state_nxt == IDLE) && finished;
   end

endmodule

// File: tb/tb_sccb_cmd_sender.sv
// Directed bench for sccb_cmd_sender (QTR=4, RST_WAIT=50): decodes the SCCB bus and
// checks bytes, ack-slot release, START/STOP, advance timing, reset and table-end handling.
module tb_sccb_cmd_sender;

   logic        clk = 1'b0;
   logic        resetn;
   logic        en;
   logic [15:0] command;
   logic        finished;
   logic        advance, sioc, siod_o, siod_oe, busy, done;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   int          adv_cyc, adv_n, oe_low, n_start, n_stop, n_rise, cnt_a, cnt_b, cnt_c;
   logic [26:0] bits, oes;

   localparam logic [26:0] OE_EXP = 27'b111111110_111111110_111111110;

   sccb_cmd_sender #(.QTR(4), .DEV_ID(8'h42), .RST_WAIT(50)) dut (
      .clk(clk), .resetn(resetn), .en(en), .command(command), .finished(finished),
      .advance(advance), .sioc(sioc), .siod_o(siod_o), .siod_oe(siod_oe),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Waits for a transfer to begin (busy high = cycle 1) and decodes the bus until the advance pulse.
   task automatic run_frame(input int drop_at, input int fin_at, input int chg_at,
                            output int a_cyc, output int a_n, output logic [26:0] b,
                            output logic [26:0] o, output int olow, output int nst,
                            output int nsp, output int nr);
      int   cyc, nb;
      logic pc, pd;
      a_cyc = -1; a_n = 0; b = '0; o = '0; olow = 0; nst = 0; nsp = 0; nr = 0; nb = 0;
      pc = 1'b1; pd = 1'b1;
      for (int i = 0; i < 20 && !busy; i++) tick();
      cyc = 1;
      while (busy && cyc < 700) begin
         if (advance) begin
            a_n++;
            if (a_cyc < 0) a_cyc = cyc;
         end
         if (!siod_oe) olow++;
         if (!pc && sioc) begin
            nr++;
            if (nb < 27) begin
               b[26-nb] = siod_o;
               o[26-nb] = siod_oe;
               nb++;
            end
         end
         if (pc && sioc && pd && !siod_o) nst++;
         if (pc && sioc && !pd && siod_o) nsp++;
         pc = sioc;
         pd = siod_o;
         if (cyc == drop_at) en = 1'b0;
         if (cyc == fin_at)  finished = 1'b1;
         if (cyc == chg_at)  command = 16'h5555;
         if (advance) break;
         tick();
         cyc++;
      end
   endtask

   task automatic check_frame(input string tag, input logic [7:0] r, input logic [7:0] v);
      chk({tag, "_adv_cycle"}, 32'(adv_cyc), 32'd468);
      chk({tag, "_adv_count"}, 32'(adv_n), 32'd1);
      chk({tag, "_id_byte"}, 32'(bits[26:19]), 32'h42);
      chk({tag, "_reg_byte"}, 32'(bits[17:10]), 32'(r));
      chk({tag, "_val_byte"}, 32'(bits[8:1]), 32'(v));
      chk({tag, "_oe_slots"}, 32'(oes), 32'(OE_EXP));
      chk({tag, "_oe_low_cycles"}, 32'(oe_low), 32'd48);
      chk({tag, "_starts"}, 32'(n_start), 32'd1);
      chk({tag, "_stops"}, 32'(n_stop), 32'd1);
      chk({tag, "_sioc_rises"}, 32'(n_rise), 32'd28);
   endtask

   initial begin
      resetn = 1'b0; en = 1'b1; finished = 1'b1; command = 16'h3A04;
      #23;
      chk("rst_sioc", 32'(sioc), 32'd1);
      chk("rst_siod", 32'(siod_o), 32'd1);
      chk("rst_oe", 32'(siod_oe), 32'd1);
      chk("rst_adv", 32'(advance), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);

      // Table already exhausted out of reset: nothing on the bus.
      resetn = 1'b1;
      cnt_a = 0; cnt_b = 0; cnt_c = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (busy) cnt_a++;
         if (!done) cnt_b++;
         if (!sioc || !siod_o) cnt_c++;
      end
      chk("fin_busy_cycles", 32'(cnt_a), 32'd0);
      chk("fin_not_done_cycles", 32'(cnt_b), 32'd0);
      chk("fin_bus_activity", 32'(cnt_c), 32'd0);

      // Normal write 3A <= 04, immediately followed by a re-latch.
      finished = 1'b0;
      run_frame(-1, -1, -1, adv_cyc, adv_n, bits, oes, oe_low, n_start, n_stop, n_rise);
      check_frame("w3a04", 8'h3A, 8'h04);
      tick();
      chk("w3a04_idle_469", 32'(busy), 32'd0);
      tick();
      chk("w3a04_relatch_470", 32'(busy), 32'd1);

      // Reset during bit 12 of the second transfer, then a full retransmission.
      for (int i = 0; i < 190; i++) tick();
      chk("pre_rst_busy", 32'(busy), 32'd1);
      #2 resetn = 1'b0;
      #1;
      chk("midrst_sioc", 32'(sioc), 32'd1);
      chk("midrst_siod", 32'(siod_o), 32'd1);
      chk("midrst_busy", 32'(busy), 32'd0);
      #2 resetn = 1'b1;
      run_frame(-1, -1, -1, adv_cyc, adv_n, bits, oes, oe_low, n_start, n_stop, n_rise);
      en = 1'b0;
      check_frame("retx", 8'h3A, 8'h04);

      // Software-reset command holds busy for RST_WAIT extra cycles.
      tick(); tick();
      command = 16'h1280; en = 1'b1;
      run_frame(-1, -1, -1, adv_cyc, adv_n, bits, oes, oe_low, n_start, n_stop, n_rise);
      check_frame("swrst", 8'h12, 8'h80);
      cnt_a = 0; cnt_b = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (busy) cnt_a++;
         if (advance) cnt_b++;
      end
      chk("swrst_wait_busy", 32'(cnt_a), 32'd50);
      chk("swrst_wait_adv", 32'(cnt_b), 32'd0);
      tick();
      chk("swrst_idle_519", 32'(busy), 32'd0);
      tick();
      chk("swrst_relatch_520", 32'(busy), 32'd1);
      en = 1'b0;
      #2 resetn = 1'b0;
      #2 resetn = 1'b1;

      // Skip marker: advance one cycle after leaving IDLE, no clocking.
      tick(); tick();
      command = 16'hFFFF; en = 1'b1;
      run_frame(-1, -1, -1, adv_cyc, adv_n, bits, oes, oe_low, n_start, n_stop, n_rise);
      en = 1'b0;
      chk("skip_adv_cycle", 32'(adv_cyc), 32'd1);
      chk("skip_sioc_rises", 32'(n_rise), 32'd0);
      chk("skip_sioc", 32'(sioc), 32'd1);
      tick();
      chk("skip_then_idle", 32'(busy), 32'd0);
      chk("skip_adv_width", 32'(advance), 32'd0);

      // en dropped during bit 5 and command changed mid-frame: frame still completes unchanged.
      command = 16'h3A04; en = 1'b1;
      run_frame(73, -1, 50, adv_cyc, adv_n, bits, oes, oe_low, n_start, n_stop, n_rise);
      check_frame("endrop", 8'h3A, 8'h04);
      cnt_a = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (busy || !sioc) cnt_a++;
      end
      chk("endrop_no_restart", 32'(cnt_a), 32'd0);

      // finished rising mid-frame: frame completes, then done.
      command = 16'h1122; en = 1'b1;
      run_frame(-1, 100, -1, adv_cyc, adv_n, bits, oes, oe_low, n_start, n_stop, n_rise);
      check_frame("finmid", 8'h11, 8'h22);
      tick();
      chk("finmid_done", 32'(done), 32'd1);
      chk("finmid_busy", 32'(busy), 32'd0);
      cnt_a = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (busy || !done) cnt_a++;
      end
      chk("finmid_hold", 32'(cnt_a), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/sccb_cmd_sender.md
SCCB_CMD_SENDER -- requirements
Module: sccb_cmd_sender

Interface
REQ-001 Parameter QTR, default 250, clk cycles per quarter SIOC period (100 kHz SIOC at 100 MHz).
REQ-002 Parameter DEV_ID, default 8'h42, SCCB write ID byte.
REQ-003 Parameter RST_WAIT, default 100000, idle cycles after a 16'h1280 software-reset write.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 en  in  1  level; permits starting new transfers.
REQ-007 command  in  16  {register address[15:8], value[7:0]} from the register table, combinational from the table address.
REQ-008 finished  in  1  table exhausted.
REQ-009 advance  out  1  one-cycle pulse; steps the table to the next command.
REQ-010 sioc  out  1  SCCB clock.
REQ-011 siod_o  out  1  SCCB data value.
REQ-012 siod_oe  out  1  SCCB data drive enable; top level builds the tristate.
REQ-013 busy  out  1  high in any state other than IDLE.
REQ-014 done  out  1  high when in IDLE with finished=1.

Function
REQ-015 States: IDLE, START, BITS, STOP, GAP, SKIP, RWAIT.
REQ-016 Quarter tick: a counter counts 0..QTR-1; each quarter lasts exactly QTR cycles; the counter clears on every state entry.
REQ-017 IDLE: sioc=1, siod_o=1, siod_oe=1; if en=1 and finished=0, latch command and DEV_ID into a 27-bit shift frame {DEV_ID,Z,reg,Z,val,Z}, go to START (or SKIP if command=16'hFFFF).
REQ-018 START, 2 quarters: q0 sioc=1 siod_o=1; q1 sioc=1 siod_o=0.
REQ-019 BITS: 27 bits MSB-first, 4 quarters each: q0-q1 sioc=0, q2-q3 sioc=1; siod_o changes only at q0 start.
REQ-020 Bits 9, 18, 27 (don't-care/ack slots): siod_oe=0 for all 4 quarters; SIOD is not sampled; no ack checking.
REQ-021 STOP, 3 quarters: q0 sioc=0 siod_o=0 siod_oe=1; q1 sioc=1 siod_o=0; q2 sioc=1 siod_o=1.
REQ-022 GAP, 4 quarters bus idle (sioc=1, siod_o=1); advance=1 on the final cycle of GAP only.
REQ-023 Total transfer, IDLE exit to advance pulse: 117*QTR cycles.
REQ-024 After GAP: if the latched command was 16'h1280, go to RWAIT for RST_WAIT cycles, else IDLE.
REQ-025 RWAIT: bus idle; returns to IDLE after RST_WAIT cycles; no advance pulse in RWAIT.
REQ-026 SKIP: lasts 1 cycle, no bus activity, advance=1 that cycle, then IDLE.
REQ-027 IDLE always spends at least one cycle after any advance pulse before latching, so the table output settles.
REQ-028 en falling mid-transfer does not abort; the transfer completes, then the block holds in IDLE.
REQ-029 finished rising mid-transfer does not abort; the block returns to IDLE, then holds with done=1.
REQ-030 command changing mid-transfer has no effect; the frame is latched.
REQ-031 All outputs are registered; glitch-free sioc/siod.

Reset
REQ-032 resetn=0 forces, immediately and asynchronously: state=IDLE, counters=0, sioc=1, siod_o=1, siod_oe=1, advance=0, busy=0, done=0.
REQ-033 Reset asserted mid-transfer abandons the frame; after release, the block restarts from the current command with a full START.

Verification (QTR=4, RST_WAIT=50)
REQ-034 command=16'h3A04, en=1 -> START then bytes 42,3A,04 decoded at sioc rising edges; siod_oe=0 in slots 9/18/27; STOP; advance pulse at cycle 468 after leaving IDLE.
REQ-035 command=16'h1280 -> normal frame; advance pulse; busy stays high 50 more cycles; next latch not before cycle 519.
REQ-036 command=16'hFFFF -> no sioc toggle; advance pulse 1 cycle after IDLE exit.
REQ-037 finished=1 from reset -> no bus activity; done=1, busy=0 indefinitely.
REQ-038 resetn pulsed low during bit 12 -> sioc=1, siod_o=1 same cycle; the full frame is retransmitted after release.
REQ-039 en dropped at bit 5 -> frame completes with one advance pulse; no new START while en=0.
